// File: rtl/tick_timer_gen.sv
// Timebase generator: runtime-reloadable divider producing a 1-cycle us strobe,
// a cascaded ms strobe, and a one-shot pulse timer counted in us ticks.
module tick_timer_gen #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned US_PER_MS = 1000,
    parameter int unsigned PLEN_W    = 16,
    parameter int unsigned DEF_DIV   = CLK_HZ / 1_000_000 - 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              pulse_start,
    input  logic [PLEN_W-1:0] pulse_len_us,
    output logic              tick_us,
    output logic              tick_ms,
    output logic              pulse_out,
    output logic              pulse_busy,
    output logic              pulse_done
);

    localparam int unsigned       MS_W      = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam logic [DIV_W-1:0]  DEF_DIV_V = DIV_W'(DEF_DIV);
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(US_PER_MS - 1);
    localparam logic [PLEN_W-1:0] REM_ONE   = PLEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  r_div_cur;
    logic [MS_W-1:0]   r_ms_cnt;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [PLEN_W-1:0] r_rem;
    logic [PLEN_W-1:0] w_rem_nxt;
    logic              r_pulse_out;
    logic              w_pulse_out_nxt;
    logic              r_pulse_done;
    logic              w_pulse_done_nxt;
    logic              w_div_term;
    logic              w_tick_us;

    assign w_div_term = (r_div_cnt == r_div_cur);
    assign w_tick_us  = en & ~clr & w_div_term;
    assign tick_us    = w_tick_us;
    assign tick_ms    = w_tick_us & (r_ms_cnt == MS_LAST);
    assign pulse_out  = r_pulse_out;
    assign pulse_done = r_pulse_done;
    assign pulse_busy = (r_state != S_IDLE);

    // A reload restarts the period from zero even while the timebase is frozen.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_div_cnt <= '0;
            r_div_cur <= DEF_DIV_V;
        end else if (clr) begin
            r_div_cnt <= '0;
        end else if (div_load) begin
            r_div_cur <= div_val;
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= w_div_term ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ms_cnt <= '0;
        end else if (clr) begin
            r_ms_cnt <= '0;
        end else if (w_tick_us) begin
            r_ms_cnt <= (r_ms_cnt == MS_LAST) ? '0 : r_ms_cnt + MS_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_pulse_out  <= 1'b0;
            r_pulse_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem_nxt;
            r_pulse_out  <= w_pulse_out_nxt;
            r_pulse_done <= w_pulse_done_nxt;
        end
    end

    // ARM waits for the next tick so the pulse width is a whole number of periods.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (pulse_start && (pulse_len_us != '0)) begin
                        w_state_nxt = S_ARM;
                        w_rem_nxt   = pulse_len_us;
                    end
                end
                S_ARM: begin
                    if (w_tick_us) w_state_nxt = S_HIGH;
                end
                S_HIGH: begin
                    if (w_tick_us) begin
                        if (r_rem == REM_ONE) w_state_nxt = S_IDLE;
                        else                  w_rem_nxt   = r_rem - REM_ONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // With en low the pulse level holds, so a frozen timebase stretches the pulse.
    always_comb begin
        w_pulse_out_nxt  = r_pulse_out;
        w_pulse_done_nxt = 1'b0;
        if (clr) begin
            w_pulse_out_nxt = 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    w_pulse_out_nxt = 1'b0;
                    if (pulse_start && (pulse_len_us == '0)) w_pulse_done_nxt = 1'b1;
                end
                S_ARM: begin
                    if (w_tick_us) w_pulse_out_nxt = 1'b1;
                end
                S_HIGH: begin
                    if (w_tick_us && (r_rem == REM_ONE)) begin
                        w_pulse_out_nxt  = 1'b0;
                        w_pulse_done_nxt = 1'b1;
                    end
                end
                default: w_pulse_out_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_timer_gen.sv
// Bench for tick_timer_gen: vector table, directed multi-cycle sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_tick_timer_gen;

    localparam int US = 20;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        div_load;
    logic [15:0] div_val;
    logic        pulse_start;
    logic [15:0] plen;
    logic        tick_us;
    logic        tick_ms;
    logic        pulse_out;
    logic        pulse_busy;
    logic        pulse_done;

    int checks   = 0;
    int failures = 0;

    tick_timer_gen #(
        .CLK_HZ   (50_000_000),
        .DIV_W    (16),
        .US_PER_MS(US),
        .PLEN_W   (16)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .en          (en),
        .clr         (clr),
        .div_load    (div_load),
        .div_val     (div_val),
        .pulse_start (pulse_start),
        .pulse_len_us(plen),
        .tick_us     (tick_us),
        .tick_ms     (tick_ms),
        .pulse_out   (pulse_out),
        .pulse_busy  (pulse_busy),
        .pulse_done  (pulse_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the period phase is the number of enabled cycles since the
    // last restart; a pulse is described by how many ticks it has seen.
    int m_k, m_p, m_tcount, m_n, m_len;
    bit m_active, m_done, m_tick;
    logic [4:0] m_exp, m_act;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_k = 0; m_p = 50; m_tcount = 0;
            m_active = 0; m_n = 0; m_len = 0; m_done = 0; m_tick = 0;
            m_exp = '0;
        end else begin
            m_tick = en && !clr && ((m_k % m_p) == m_p - 1);
            m_exp = {m_tick, m_tick && ((m_tcount % US) == US - 1),
                     m_active && (m_n >= 1) && (m_n <= m_len), m_active, m_done};
        end
        m_act = {tick_us, tick_ms, pulse_out, pulse_busy, pulse_done};
        checks++;
        if (m_act !== m_exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL model t=%0t got %b expected %b (tick_us,tick_ms,out,busy,done)",
                         $time, m_act, m_exp);
        end
        if (rst_n) begin
            if (clr) begin
                m_k = 0; m_tcount = 0; m_active = 0; m_done = 0;
            end else begin
                if (div_load) begin
                    m_p = int'(div_val) + 1;
                    m_k = 0;
                end else if (en) begin
                    m_k++;
                end
                if (m_tick) m_tcount++;
                m_done = 0;
                if (en) begin
                    if (m_active) begin
                        if (m_tick) begin
                            m_n++;
                            if (m_n == m_len + 1) begin
                                m_active = 0;
                                m_done   = 1;
                            end
                        end
                    end else if (pulse_start) begin
                        if (plen == 16'd0) m_done = 1;
                        else begin
                            m_active = 1; m_n = 0; m_len = int'(plen);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; div_load = 0; div_val = '0; pulse_start = 0; plen = '0;
    endtask

    task automatic wait_tick(output int n);
        bit hit;
        hit = 0;
        n = -1;
        for (int i = 1; i <= 200 && !hit; i++) begin
            @(negedge clk);
            if (tick_us) begin
                hit = 1;
                n = i;
            end
            next_cycle();
        end
    endtask

    task automatic measure(input int cycles, output int width, output int dones,
                           output int done_ok);
        bit prev;
        prev = 0; width = 0; dones = 0; done_ok = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (pulse_out) width++;
            if (pulse_done) begin
                dones++;
                if (!pulse_out && prev) done_ok = 1;
            end
            prev = pulse_out;
            next_cycle();
        end
    endtask

    task automatic start_pulse(input int len);
        pulse_start = 1;
        plen = 16'(len);
        @(negedge clk);
        chk("start_busy_low", int'(pulse_busy), 0);
        next_cycle();
        pulse_start = 0;
        plen = '0;
    endtask

    typedef struct {
        bit         en;
        bit         clr;
        bit         ld;
        int         dv;
        bit         ps;
        int         pl;
        logic [4:0] exp_o;
    } vec_t;

    vec_t tbl[24];

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int n, w, d, ok, first_tick, last_tick, n_ticks, first_ms, n_ms;

        // {en, clr, load, div_val, start, len, {tick_us,tick_ms,out,busy,done}}
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 2, 1'b0, 0, 5'b00000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 2, 5'b00000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00010};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10010};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00110};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00110};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 5, 5'b00110};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10110};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00110};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00110};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10110};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00001};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 5'b00000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10001};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 7, 1'b0, 0, 5'b00000};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00000};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10000};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 5'b00000};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10000};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10000};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 5'b00000};
        tbl[22] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 5'b00000};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 5'b10000};

        rst_n = 0; en = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({tick_us, tick_ms, pulse_out, pulse_busy, pulse_done}), 0);
        rst_n = 1;

        for (int r = 0; r < 24; r++) begin
            en = tbl[r].en; clr = tbl[r].clr; div_load = tbl[r].ld;
            div_val = 16'(tbl[r].dv); pulse_start = tbl[r].ps; plen = 16'(tbl[r].pl);
            @(negedge clk);
            checks++;
            if ({tick_us, tick_ms, pulse_out, pulse_busy, pulse_done} !== tbl[r].exp_o) begin
                failures++;
                $display("FAIL table row %0d: got %b expected %b", r,
                         {tick_us, tick_ms, pulse_out, pulse_busy, pulse_done}, tbl[r].exp_o);
            end
            next_cycle();
        end
        idle_inputs();

        // Default divider and ms cascade straight out of reset.
        rst_n = 0; en = 0;
        next_cycle();
        next_cycle();
        rst_n = 1; en = 1;
        first_tick = -1; last_tick = -1; n_ticks = 0; first_ms = -1; n_ms = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (tick_us) begin
                if (first_tick < 0) first_tick = c;
                last_tick = c;
                n_ticks++;
            end
            if (tick_ms) begin
                if (first_ms < 0) first_ms = c;
                n_ms++;
            end
            next_cycle();
        end
        chk("first_tick_us_cycle", first_tick, 50);
        chk("tick_us_count", n_ticks, 22);
        chk("last_tick_us_cycle", last_tick, 1100);
        chk("first_tick_ms_cycle", first_ms, 1000);
        chk("tick_ms_count", n_ms, 1);

        // Reload mid-count.
        repeat (20) next_cycle();
        div_load = 1; div_val = 16'd9;
        next_cycle();
        idle_inputs();
        wait_tick(n);
        chk("divload_first_tick", n, 10);
        wait_tick(n);
        chk("divload_period", n, 10);
        div_load = 1; div_val = 16'd49;
        next_cycle();
        idle_inputs();

        // Pulse of 10 us at 50 cycles per us.
        start_pulse(10);
        measure(700, w, d, ok);
        chk("pulse10_width", w, 500);
        chk("pulse10_done_count", d, 1);
        chk("pulse10_done_on_fall", ok, 1);

        // Zero-length pulse.
        start_pulse(0);
        @(negedge clk);
        chk("len0_done", int'(pulse_done), 1);
        chk("len0_out", int'(pulse_out), 0);
        chk("len0_busy", int'(pulse_busy), 0);
        next_cycle();
        @(negedge clk);
        chk("len0_done_single", int'(pulse_done), 0);
        next_cycle();

        // Clear mid-pulse.
        start_pulse(10);
        repeat (250) next_cycle();
        clr = 1;
        @(negedge clk);
        chk("clr_cycle_out_still_high", int'(pulse_out), 1);
        next_cycle();
        clr = 0;
        @(negedge clk);
        chk("clr_out", int'(pulse_out), 0);
        chk("clr_busy", int'(pulse_busy), 0);
        chk("clr_no_done", int'(pulse_done), 0);
        next_cycle();
        measure(600, w, d, ok);
        chk("clr_no_later_pulse", w, 0);
        chk("clr_no_later_done", d, 0);

        // Freeze 37 cycles mid-pulse plus a start while busy.
        start_pulse(10);
        w = 0; d = 0;
        for (int i = 1; i <= 800; i++) begin
            en = !(i >= 150 && i < 187);
            pulse_start = (i == 120);
            plen = (i == 120) ? 16'd3 : 16'd0;
            @(negedge clk);
            if (pulse_out) w++;
            if (pulse_done) d++;
            next_cycle();
        end
        idle_inputs(); en = 1;
        chk("freeze_width", w, 537);
        chk("freeze_done_count", d, 1);
        chk("freeze_busy_end", int'(pulse_busy), 0);

        // Asynchronous reset mid-pulse.
        start_pulse(10);
        repeat (100) next_cycle();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_rst_out", int'(pulse_out), 0);
        chk("async_rst_busy", int'(pulse_busy), 0);
        next_cycle();
        next_cycle();
        rst_n = 1;
        measure(600, w, d, ok);
        chk("async_rst_no_done", d, 0);
        chk("async_rst_no_pulse", w, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            rst_n       = ($urandom_range(0, 999) != 0);
            en          = ($urandom_range(0, 9) != 0);
            clr         = ($urandom_range(0, 99) == 0);
            div_load    = ($urandom_range(0, 59) == 0);
            div_val     = 16'($urandom_range(0, 7));
            pulse_start = ($urandom_range(0, 19) == 0);
            plen        = 16'($urandom_range(0, 4));
            next_cycle();
        end
        rst_n = 1;
        idle_inputs();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
